// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, sequencer step codes, control-strobe bit
// positions and the control-word payload passed from step_decoder to the top.
package cpu_pkg;

  localparam int unsigned OPW   = 5;
  localparam int unsigned STEPW = 4;
  localparam int unsigned DRVW  = 9;
  localparam int unsigned LDW   = 11;
  localparam int unsigned GSELW = 4;

  // Opcodes (IR[31:27])
  localparam logic [OPW-1:0] OP_LD   = 5'd0;
  localparam logic [OPW-1:0] OP_LDI  = 5'd1;
  localparam logic [OPW-1:0] OP_ST   = 5'd2;
  localparam logic [OPW-1:0] OP_ADD  = 5'd3;
  localparam logic [OPW-1:0] OP_SUB  = 5'd4;
  localparam logic [OPW-1:0] OP_AND  = 5'd5;
  localparam logic [OPW-1:0] OP_OR   = 5'd6;
  localparam logic [OPW-1:0] OP_SHR  = 5'd7;
  localparam logic [OPW-1:0] OP_SHRA = 5'd8;
  localparam logic [OPW-1:0] OP_SHL  = 5'd9;
  localparam logic [OPW-1:0] OP_ROR  = 5'd10;
  localparam logic [OPW-1:0] OP_ROL  = 5'd11;
  localparam logic [OPW-1:0] OP_ADDI = 5'd12;
  localparam logic [OPW-1:0] OP_ANDI = 5'd13;
  localparam logic [OPW-1:0] OP_ORI  = 5'd14;
  localparam logic [OPW-1:0] OP_MUL  = 5'd15;
  localparam logic [OPW-1:0] OP_DIV  = 5'd16;
  localparam logic [OPW-1:0] OP_NEG  = 5'd17;
  localparam logic [OPW-1:0] OP_NOT  = 5'd18;
  localparam logic [OPW-1:0] OP_BR   = 5'd19;
  localparam logic [OPW-1:0] OP_JR   = 5'd20;
  localparam logic [OPW-1:0] OP_JAL  = 5'd21;
  localparam logic [OPW-1:0] OP_IN   = 5'd22;
  localparam logic [OPW-1:0] OP_OUT  = 5'd23;
  localparam logic [OPW-1:0] OP_MFHI = 5'd24;
  localparam logic [OPW-1:0] OP_MFLO = 5'd25;
  localparam logic [OPW-1:0] OP_NOP  = 5'd26;
  localparam logic [OPW-1:0] OP_HALT = 5'd27;

  // Sequencer steps
  localparam logic [STEPW-1:0] ST_T0       = 4'd0;
  localparam logic [STEPW-1:0] ST_T1       = 4'd1;
  localparam logic [STEPW-1:0] ST_T2       = 4'd2;
  localparam logic [STEPW-1:0] ST_T3       = 4'd3;
  localparam logic [STEPW-1:0] ST_T4       = 4'd4;
  localparam logic [STEPW-1:0] ST_T5       = 4'd5;
  localparam logic [STEPW-1:0] ST_T6       = 4'd6;
  localparam logic [STEPW-1:0] ST_T7       = 4'd7;
  localparam logic [STEPW-1:0] ST_DIV_WAIT = 4'd8;
  localparam logic [STEPW-1:0] ST_HALT     = 4'd9;

  // drv_en bit positions
  localparam int unsigned DRV_R_OUT   = 8;
  localparam int unsigned DRV_C_OUT   = 7;
  localparam int unsigned DRV_IN_OUT  = 6;
  localparam int unsigned DRV_MDR_OUT = 5;
  localparam int unsigned DRV_PC_OUT  = 4;
  localparam int unsigned DRV_ZLO_OUT = 3;
  localparam int unsigned DRV_ZHI_OUT = 2;
  localparam int unsigned DRV_LO_OUT  = 1;
  localparam int unsigned DRV_HI_OUT  = 0;

  // ld_en bit positions
  localparam int unsigned LD_RIN    = 10;
  localparam int unsigned LD_MDR_RD = 9;
  localparam int unsigned LD_MAR_RD = 8;
  localparam int unsigned LD_HI_RD  = 7;
  localparam int unsigned LD_LO_RD  = 6;
  localparam int unsigned LD_ZHI_RD = 5;
  localparam int unsigned LD_ZLO_RD = 4;
  localparam int unsigned LD_PC_RD  = 3;
  localparam int unsigned LD_OUT_RD = 2;
  localparam int unsigned LD_Y_RD   = 1;
  localparam int unsigned LD_IR_RD  = 0;

  // gsel bit positions
  localparam int unsigned G_GRA   = 3;
  localparam int unsigned G_GRB   = 2;
  localparam int unsigned G_GRC   = 1;
  localparam int unsigned G_BAOUT = 0;

  typedef struct packed {
    logic [DRVW-1:0]  drv;
    logic [LDW-1:0]   ld;
    logic [GSELW-1:0] gsel;
    logic [OPW-1:0]   op_sel;
    logic             inc_pc;
    logic             read;
    logic             write;
    logic             con_in;
    logic             reset_div;
    logic             illegal_op;
  } ctrl_t;

  // Three-register ALU instructions add..rol
  function automatic logic is_rtype(input logic [OPW-1:0] op);
    return (op >= OP_ADD) && (op <= OP_ROL);
  endfunction

  // ALU operation used by the immediate forms
  function automatic logic [OPW-1:0] imm_alu_op(input logic [OPW-1:0] op);
    logic [OPW-1:0] res;
    case (op)
      OP_ANDI: res = OP_AND;
      OP_ORI:  res = OP_OR;
      default: res = OP_ADD;
    endcase
    return res;
  endfunction

  // Last execute step of each instruction; everything not listed ends in T3
  function automatic logic [STEPW-1:0] final_step(input logic [OPW-1:0] op);
    logic [STEPW-1:0] res;
    if (is_rtype(op)) begin
      res = ST_T5;
    end else begin
      case (op)
        OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: res = ST_T5;
        OP_NEG, OP_NOT, OP_JAL:           res = ST_T4;
        OP_MUL, OP_DIV, OP_BR:            res = ST_T6;
        OP_LD, OP_ST:                     res = ST_T7;
        default:                          res = ST_T3;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/control_sequencer_step_decoder.sv
// step_decoder: combinational map from (step, opcode, CON_output,
// calc_finished) to the full datapath control word.
// Ports:
//   state         in  current sequencer step
//   opcode        in  IR opcode
//   con_output    in  branch-condition flag
//   calc_finished in  divider done
//   ctrl          out control word (drivers, loads, selects, op_sel, strobes)
module step_decoder
  import cpu_pkg::*;
(
  input  logic [STEPW-1:0] state,
  input  logic [OPW-1:0]   opcode,
  input  logic             con_output,
  input  logic             calc_finished,
  output ctrl_t            ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_T0: begin
        ctrl.drv[DRV_PC_OUT] = 1'b1;
        ctrl.ld[LD_MAR_RD]   = 1'b1;
        ctrl.inc_pc          = 1'b1;
      end
      ST_T1: begin
        ctrl.read           = 1'b1;
        ctrl.ld[LD_MDR_RD]  = 1'b1;
      end
      ST_T2: begin
        ctrl.drv[DRV_MDR_OUT] = 1'b1;
        ctrl.ld[LD_IR_RD]     = 1'b1;
      end

      ST_T3: begin
        if (is_rtype(opcode)) begin
          ctrl.drv[DRV_R_OUT] = 1'b1;
          ctrl.gsel[G_GRB]    = 1'b1;
          ctrl.ld[LD_Y_RD]    = 1'b1;
        end else begin
          case (opcode)
            OP_ADDI, OP_ANDI, OP_ORI: begin
              ctrl.drv[DRV_R_OUT] = 1'b1;
              ctrl.gsel[G_GRB]    = 1'b1;
              ctrl.ld[LD_Y_RD]    = 1'b1;
            end
            OP_LD, OP_LDI, OP_ST: begin
              ctrl.drv[DRV_R_OUT]  = 1'b1;
              ctrl.gsel[G_GRB]     = 1'b1;
              ctrl.gsel[G_BAOUT]   = 1'b1;
              ctrl.ld[LD_Y_RD]     = 1'b1;
            end
            OP_MUL, OP_DIV: begin
              ctrl.drv[DRV_R_OUT] = 1'b1;
              ctrl.gsel[G_GRA]    = 1'b1;
              ctrl.ld[LD_Y_RD]    = 1'b1;
            end
            OP_NEG, OP_NOT: begin
              ctrl.drv[DRV_R_OUT] = 1'b1;
              ctrl.gsel[G_GRB]    = 1'b1;
              ctrl.op_sel         = opcode;
              ctrl.ld[LD_ZLO_RD]  = 1'b1;
            end
            OP_BR: begin
              ctrl.drv[DRV_R_OUT] = 1'b1;
              ctrl.gsel[G_GRA]    = 1'b1;
              ctrl.con_in         = 1'b1;
            end
            OP_JR: begin
              ctrl.drv[DRV_R_OUT] = 1'b1;
              ctrl.gsel[G_GRA]    = 1'b1;
              ctrl.ld[LD_PC_RD]   = 1'b1;
            end
            // Link register is addressed through the rb field
            OP_JAL: begin
              ctrl.drv[DRV_PC_OUT] = 1'b1;
              ctrl.gsel[G_GRB]     = 1'b1;
              ctrl.ld[LD_RIN]      = 1'b1;
            end
            OP_IN: begin
              ctrl.drv[DRV_IN_OUT] = 1'b1;
              ctrl.gsel[G_GRA]     = 1'b1;
              ctrl.ld[LD_RIN]      = 1'b1;
            end
            OP_OUT: begin
              ctrl.drv[DRV_R_OUT] = 1'b1;
              ctrl.gsel[G_GRA]    = 1'b1;
              ctrl.ld[LD_OUT_RD]  = 1'b1;
            end
            OP_MFHI: begin
              ctrl.drv[DRV_HI_OUT] = 1'b1;
              ctrl.gsel[G_GRA]     = 1'b1;
              ctrl.ld[LD_RIN]      = 1'b1;
            end
            OP_MFLO: begin
              ctrl.drv[DRV_LO_OUT] = 1'b1;
              ctrl.gsel[G_GRA]     = 1'b1;
              ctrl.ld[LD_RIN]      = 1'b1;
            end
            OP_NOP, OP_HALT: begin
            end
            default: ctrl.illegal_op = (opcode > OP_HALT);
          endcase
        end
      end

      ST_T4: begin
        if (is_rtype(opcode)) begin
          ctrl.drv[DRV_R_OUT] = 1'b1;
          ctrl.gsel[G_GRC]    = 1'b1;
          ctrl.op_sel         = opcode;
          ctrl.ld[LD_ZLO_RD]  = 1'b1;
        end else begin
          case (opcode)
            OP_ADDI, OP_ANDI, OP_ORI, OP_LD, OP_LDI, OP_ST: begin
              ctrl.drv[DRV_C_OUT] = 1'b1;
              ctrl.op_sel         = imm_alu_op(opcode);
              ctrl.ld[LD_ZLO_RD]  = 1'b1;
            end
            OP_NEG, OP_NOT: begin
              ctrl.drv[DRV_ZLO_OUT] = 1'b1;
              ctrl.gsel[G_GRA]      = 1'b1;
              ctrl.ld[LD_RIN]       = 1'b1;
            end
            OP_MUL: begin
              ctrl.drv[DRV_R_OUT] = 1'b1;
              ctrl.gsel[G_GRB]    = 1'b1;
              ctrl.op_sel         = opcode;
              ctrl.ld[LD_ZHI_RD]  = 1'b1;
              ctrl.ld[LD_ZLO_RD]  = 1'b1;
            end
            // Divider is started here; done is not looked at until DIV_WAIT
            OP_DIV: begin
              ctrl.drv[DRV_R_OUT] = 1'b1;
              ctrl.gsel[G_GRB]    = 1'b1;
              ctrl.op_sel         = opcode;
              ctrl.reset_div      = 1'b1;
            end
            OP_BR: begin
              ctrl.drv[DRV_PC_OUT] = 1'b1;
              ctrl.ld[LD_Y_RD]     = 1'b1;
            end
            OP_JAL: begin
              ctrl.drv[DRV_R_OUT] = 1'b1;
              ctrl.gsel[G_GRA]    = 1'b1;
              ctrl.ld[LD_PC_RD]   = 1'b1;
            end
            default: begin
            end
          endcase
        end
      end

      // Operands held on the bus until the divider reports completion
      ST_DIV_WAIT: begin
        ctrl.drv[DRV_R_OUT] = 1'b1;
        ctrl.gsel[G_GRB]    = 1'b1;
        ctrl.op_sel         = opcode;
        ctrl.ld[LD_ZHI_RD]  = calc_finished;
        ctrl.ld[LD_ZLO_RD]  = calc_finished;
      end

      ST_T5: begin
        if (is_rtype(opcode)) begin
          ctrl.drv[DRV_ZLO_OUT] = 1'b1;
          ctrl.gsel[G_GRA]      = 1'b1;
          ctrl.ld[LD_RIN]       = 1'b1;
        end else begin
          case (opcode)
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
              ctrl.drv[DRV_ZLO_OUT] = 1'b1;
              ctrl.gsel[G_GRA]      = 1'b1;
              ctrl.ld[LD_RIN]       = 1'b1;
            end
            OP_MUL, OP_DIV: begin
              ctrl.drv[DRV_ZLO_OUT] = 1'b1;
              ctrl.ld[LD_LO_RD]     = 1'b1;
            end
            OP_LD, OP_ST: begin
              ctrl.drv[DRV_ZLO_OUT] = 1'b1;
              ctrl.ld[LD_MAR_RD]    = 1'b1;
            end
            OP_BR: begin
              ctrl.drv[DRV_C_OUT] = 1'b1;
              ctrl.op_sel         = OP_ADD;
              ctrl.ld[LD_ZLO_RD]  = 1'b1;
            end
            default: begin
            end
          endcase
        end
      end

      ST_T6: begin
        case (opcode)
          OP_MUL, OP_DIV: begin
            ctrl.drv[DRV_ZHI_OUT] = 1'b1;
            ctrl.ld[LD_HI_RD]     = 1'b1;
          end
          OP_LD: begin
            ctrl.read          = 1'b1;
            ctrl.ld[LD_MDR_RD] = 1'b1;
          end
          // Store data enters MDR from the bus, not from memory
          OP_ST: begin
            ctrl.drv[DRV_R_OUT] = 1'b1;
            ctrl.gsel[G_GRA]    = 1'b1;
            ctrl.ld[LD_MDR_RD]  = 1'b1;
          end
          OP_BR: begin
            ctrl.drv[DRV_ZLO_OUT] = con_output;
            ctrl.ld[LD_PC_RD]     = con_output;
          end
          default: begin
          end
        endcase
      end

      ST_T7: begin
        case (opcode)
          OP_LD: begin
            ctrl.drv[DRV_MDR_OUT] = 1'b1;
            ctrl.gsel[G_GRA]      = 1'b1;
            ctrl.ld[LD_RIN]       = 1'b1;
          end
          OP_ST:   ctrl.write = 1'b1;
          default: begin
          end
        endcase
      end

      default: begin
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit.
// Holds the step register and next-step logic; step_decoder turns the
// current step and opcode into the control word.
// Ports:
//   clk, clr                        clock, synchronous active-high reset
//   ir_opcode, CON_output,
//   calc_finished                   opcode, branch flag, divider done
//   drv_en, ld_en, gsel, op_sel     bus drivers, loads, register selects, ALU op
//   IncPC, Read, Write, CONin,
//   reset_div                       datapath strobes
//   run, illegal_op                 executing flag, undefined-opcode pulse
module control_sequencer
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic [OPW-1:0]   ir_opcode,
  input  logic             CON_output,
  input  logic             calc_finished,
  output logic [DRVW-1:0]  drv_en,
  output logic [LDW-1:0]   ld_en,
  output logic [GSELW-1:0] gsel,
  output logic [OPW-1:0]   op_sel,
  output logic             IncPC,
  output logic             Read,
  output logic             Write,
  output logic             CONin,
  output logic             reset_div,
  output logic             run,
  output logic             illegal_op
);

  logic [STEPW-1:0] state;
  logic [STEPW-1:0] state_next;
  ctrl_t            ctrl;
  ctrl_t            ctrl_out;

  // Step register
  always_ff @(posedge clk) begin
    if (clr) state <= ST_T0;
    else     state <= state_next;
  end

  // Next step: fetch is fixed, execute ends at the opcode's final step
  always_comb begin
    state_next = state;
    case (state)
      ST_T0: state_next = ST_T1;
      ST_T1: state_next = ST_T2;
      ST_T2: state_next = ST_T3;
      ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        if ((state == ST_T3) && (ir_opcode == OP_HALT))
          state_next = ST_HALT;
        else if ((state == ST_T4) && (ir_opcode == OP_DIV))
          state_next = ST_DIV_WAIT;
        else if (state >= final_step(ir_opcode))
          state_next = ST_T0;
        else
          state_next = STEPW'(state + 1'b1);
      end
      ST_DIV_WAIT: if (calc_finished) state_next = ST_T5;
      ST_HALT:     state_next = ST_HALT;
      default:     state_next = ST_T0;
    endcase
  end

  step_decoder u_step_decoder (
    .state         (state),
    .opcode        (ir_opcode),
    .con_output    (CON_output),
    .calc_finished (calc_finished),
    .ctrl          (ctrl)
  );

  // Everything is forced quiet while clr is held, so nothing fires in the
  // reset cycle even if the register still holds a stale execute step
  assign ctrl_out   = clr ? '0 : ctrl;
  assign drv_en     = ctrl_out.drv;
  assign ld_en      = ctrl_out.ld;
  assign gsel       = ctrl_out.gsel;
  assign op_sel     = ctrl_out.op_sel;
  assign IncPC      = ctrl_out.inc_pc;
  assign Read       = ctrl_out.read;
  assign Write      = ctrl_out.write;
  assign CONin      = ctrl_out.con_in;
  assign reset_div  = ctrl_out.reset_div;
  assign illegal_op = ctrl_out.illegal_op;
  assign run        = !clr && (state != ST_HALT);

endmodule
